// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and helpers for the HI/LO multiply/divide unit.
// Operation codes, FSM state encoding and small op-decoding helpers.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // True for the two divide operations.
    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for operations that treat a and b as two's-complement values.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

endpackage

// File: rtl/hilo_step.sv
// hilo_step: one combinational iteration of the radix-2 engine.
// Multiply: shift-add on {upper,lower}, lower holds the remaining multiplier
// bits and collects product bits from the top.
// Divide: restoring shift-subtract, upper is the partial remainder and lower
// shifts the dividend out while the quotient bits shift in.
module hilo_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] upper_i,
    input  logic [WIDTH-1:0] lower_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] upper_o,
    output logic [WIDTH-1:0] lower_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rs;
    logic [WIDTH:0] diff;

    // Single shift-add or shift-subtract step selected by div_i.
    always_comb begin
        sum  = {1'b0, upper_i} + (lower_i[0] ? {1'b0, m_i} : '0);
        rs   = {upper_i, lower_i[WIDTH-1]};
        // rs < 2*m always, so bit WIDTH of the difference is a clean borrow flag.
        diff = rs - {1'b0, m_i};
        if (div_i) begin
            if (!diff[WIDTH]) begin
                upper_o = diff[WIDTH-1:0];
                lower_o = {lower_i[WIDTH-2:0], 1'b1};
            end else begin
                upper_o = rs[WIDTH-1:0];
                lower_o = {lower_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            upper_o = sum[WIDTH:1];
            lower_o = {sum[0], lower_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with an iterative radix-2 mul/div engine.
// Engine works on operand magnitudes; signs are applied in the FIX state.
// WIDTH must be even and at least 4.
// Optional feature macro: HILO_MADD_EN enables MADD/MADDU accumulate into
// {hi,lo}; without it op codes 4 and 5 are rejected like any illegal code.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             divz,
    output logic [WIDTH-1:0] rdhi,
    output logic [WIDTH-1:0] rdlo
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic               neg_q;    // sign of product or quotient
    logic               nrem_q;   // sign of remainder (follows dividend)
    logic [WIDTH-1:0]   up_q;     // product high half / partial remainder
    logic [WIDTH-1:0]   low_q;    // multiplier / dividend-quotient shifter
    logic [WIDTH-1:0]   m_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               divz_q;

    logic [WIDTH-1:0]   up_d;
    logic [WIDTH-1:0]   low_d;

    logic               legal;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
`ifdef HILO_MADD_EN
    logic [2*WIDTH-1:0] acc;
`endif

    // Decode the incoming op: legality and operand magnitudes for the start edge.
    always_comb begin
`ifdef HILO_MADD_EN
        legal = (op <= 3'd5);
`else
        legal = (op <= 3'd3);
`endif
        sgn   = is_signed_op(op);
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    hilo_step #(.WIDTH(WIDTH)) u_step (
        .div_i   (is_div(op_q)),
        .upper_i (up_q),
        .lower_i (low_q),
        .m_i     (m_q),
        .upper_o (up_d),
        .lower_o (low_d)
    );

    // Sign fix-up of the finished magnitudes into the values written to HI/LO.
    always_comb begin
        prod_mag = {up_q, low_q};
        prod_s   = neg_q ? (~prod_mag + 1'b1) : prod_mag;
        res_hi   = prod_s[2*WIDTH-1:WIDTH];
        res_lo   = prod_s[WIDTH-1:0];
`ifdef HILO_MADD_EN
        // HI/LO cannot change while busy, so they still hold the start-edge values.
        acc      = {hi_q, lo_q} + prod_s;
        if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
            res_hi = acc[2*WIDTH-1:WIDTH];
            res_lo = acc[WIDTH-1:0];
        end
`endif
        if (is_div(op_q)) begin
            res_lo = neg_q  ? (~low_q + 1'b1) : low_q;
            res_hi = nrem_q ? (~up_q + 1'b1)  : up_q;
        end
    end

    // Control FSM, iteration counter, work registers and HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            nrem_q  <= 1'b0;
            up_q    <= '0;
            low_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            divz_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && legal) begin
                        op_q    <= op;
                        cnt_q   <= '0;
                        up_q    <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        nrem_q  <= is_div(op) & a_neg;
                        low_q   <= is_div(op) ? a_mag : b_mag;
                        m_q     <= is_div(op) ? b_mag : a_mag;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        if (we_hi) hi_q <= wd;
                        if (we_lo) lo_q <= wd;
                    end
                end
                S_RUN: begin
                    if (is_div(op_q) && (m_q == '0)) begin
                        done_q  <= 1'b1;
                        divz_q  <= 1'b1;
                        state_q <= S_FIX;
                    end else begin
                        up_q  <= up_d;
                        low_q <= low_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    // divz_q is high exactly in the FIX cycle of a divide by zero.
                    if (!divz_q) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign divz = divz_q;
    assign rdhi = hi_q;
    assign rdlo = lo_q;

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Parametrised successor to the HI/LO special register pair: holds HI/LO and adds an iterative radix-2 multiply/divide engine that writes them.
- Sits beside the main ALU in the MIPS datapath.
  - Serves mult/multu/div/divu plus mthi/mtlo.
  - mfhi/mflo read the HI/LO ports combinationally.
- The controller stalls on busy.

Parameters:
- WIDTH, 32: operand and HI/LO width. Must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation op on a, b; accepted only when busy=0
- op  in  3  operation code (package enum)
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- we_hi  in  1  mthi write enable
- we_lo  in  1  mtlo write enable
- wd  in  WIDTH  mthi/mtlo write data
- busy  out  1  engine running; controller must stall mfhi/mflo/start
- done  out  1  one-cycle pulse on the cycle HI/LO take a result
- divz  out  1  one-cycle pulse with done when a divide had b=0
- rdhi  out  WIDTH  HI contents
- rdlo  out  WIDTH  LO contents

Behaviour:
- Reset (sync, any state, including mid-operation):
  - state=IDLE.
  - hi=lo=0; busy=done=divz=0.
  - Counter and work registers cleared.
- Ops:
  - MULT=0, MULTU=1, DIV=2, DIVU=3.
  - MADD=4, MADDU=5 are legal only with the optional feature.
  - Other codes: start ignored, no state change.
- FSM IDLE:
  - start=1 with a legal op: latch operand magnitudes (absolute value for signed ops), result signs and op; counter=0; go to RUN.
  - Otherwise, we_hi/we_lo write wd into hi/lo at the edge. Both may be written in the same cycle.
  - start and we_* in the same cycle: start wins; the writes are dropped.
- FSM RUN:
  - One shift-add (mult) or one restoring shift-subtract (div) step per cycle; counter increments.
  - After exactly WIDTH steps, go to FIX.
  - Divide with b=0: skip straight to FIX on the first RUN cycle.
- FSM FIX: apply sign correction, write hi/lo, assert done for one cycle, return to IDLE.
- busy:
  - busy=1 in RUN and FIX, 0 in IDLE.
  - Start accepted at edge N: busy=1 for cycles N+1 .. N+WIDTH+1.
  - done=1 in cycle N+WIDTH+1; new hi/lo visible from cycle N+WIDTH+2.
- Multiply results: {hi,lo} = full 2*WIDTH-bit product. Signed for MULT, unsigned for MULTU.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
  - Signed MIN / -1: lo=MIN, hi=0. Wraps, no flag.
  - b=0: hi and lo unchanged; done=1 and divz=1 together.
- start, we_hi and we_lo asserted while busy=1: ignored with no effect. The controller must not issue them.
- rdhi/rdlo are direct register outputs. They hold their old values during RUN and change only at the FIX edge.

Optional Feature:
- Macro: HILO_MADD_EN.
- Defined: MADD/MADDU are legal.
  - {hi,lo} += the signed/unsigned 2*WIDTH-bit product, modulo 2^(2*WIDTH).
  - The accumulate happens in FIX using the hi/lo values held at the start edge.
  - Latency is identical to MULT.
- Undefined:
  - Op codes 4 and 5 are treated as illegal; start is ignored.
  - No accumulate adder is synthesised.

Decomposition:
- Package hilo_pkg:
  - op enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU).
  - state enum (S_IDLE, S_RUN, S_FIX).
  - Helper function is_div(op).
- One natural sub-module: hilo_step, a combinational single-iteration shift-add / shift-subtract datapath.
- The FSM, counter, sign fix-up and HI/LO registers stay in hilo_muldiv.

Test Plan:
- Reset during RUN (cycle 5 of a MULT) -> next cycle busy=0, rdhi=rdlo=0, no done pulse afterwards.
- WIDTH=32, MULT a=-3 (0xFFFFFFFD), b=7 -> done at start+33; rdhi=0xFFFFFFFF, rdlo=0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 with hi=0x11, lo=0x22 preloaded -> done=divz=1 on the same cycle; hi=0x11, lo=0x22 unchanged.
- mthi 0xAAAA then mtlo 0x5555 while idle -> visible the next cycle. start+we_hi in the same cycle -> write dropped. we_lo and a second start during busy -> ignored, result unchanged.
- HILO_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. Macro undefined: op=4 start -> busy stays 0.
